imem_loader: RTL and testbench

Boot-time writer for the CPU's instruction memory: accepts a byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words, and writes them at byte addresses 0, 2, 4, … (matching the PC's +2 stepping). It sits beside `cpu` and holds the core in reset until a complete, well-formed image has been written.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/imem_loader_if.sv | 11 +
 rtl/imem_loader_byte_pair_assembler.sv | 28 ++
 rtl/imem_loader.sv | 119 +++++++++++
 tb/tb_imem_loader.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared states and constants for the instruction-memory boot loader.
package imem_loader_pkg;
    localparam int HDR_BYTES     = 2;
    localparam int MAX_WORDS_DEF = 256;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_DONE,
        S_ERROR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CHECK
`endif
    } state_e;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(parameter int ADDR_W = 16);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    modport master (output in_valid, in_data, input in_ready, imem_we, imem_addr, imem_wdata);
    modport slave  (input in_valid, in_data, output in_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_loader_byte_pair_assembler.sv
// byte_pair_assembler: holds the high byte and emits a registered {hi, lo} word with a one-cycle valid pulse.
module byte_pair_assembler (
    input  logic        clock,
    input  logic        reset,
    input  logic        clr_i,
    input  logic        hi_we_i,
    input  logic        lo_we_i,
    input  logic [7:0]  data_i,
    output logic        valid_o,
    output logic [15:0] word_o
);
    logic [7:0]  hi_q;
    logic [15:0] word_q;
    logic        valid_q;
    always_ff @(posedge clock) begin
        if (reset || clr_i) begin
            hi_q    <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (hi_we_i) hi_q <= data_i;
            if (lo_we_i) word_q <= {hi_q, data_i};
            valid_q <= lo_we_i;
        end
    end
    assign valid_o = valid_q;
    assign word_o  = word_q;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer of 16-bit big-endian words into instruction memory; holds the CPU until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR byte over all data bytes.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MAX_WORDS = MAX_WORDS_DEF,
    parameter int ADDR_W    = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start_i,
    imem_loader_if.slave bus,
    output logic         cpu_hold_o,
    output logic         done_o,
    output logic         error_o,
    output logic [15:0]  word_count_o
);
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e FIN = S_CHECK;
    logic [7:0] csum_q, csum_d;
`else
    localparam state_e FIN = S_DONE;
`endif
    state_e                 state_q, state_d;
    logic [7:0]             len_hi_q, len_hi_d;
    logic [8*HDR_BYTES-1:0] len_q, len_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   rdy_q, done_q, err_q, hold_q;
    logic                   xfer, restart, hi_we, lo_we, last;
    logic [15:0]            n;
    always_comb begin
        xfer     = bus.in_valid && rdy_q;
        n        = {len_hi_q, bus.in_data};
        last     = (cnt_q + 16'd1) == len_q;
        restart  = start_i && (state_q inside {S_IDLE, S_DONE, S_ERROR});
        hi_we    = xfer && state_q == S_DATA_HI;
        lo_we    = xfer && state_q == S_DATA_LO;
        state_d  = state_q;
        len_hi_d = len_hi_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: if (start_i) state_d = S_LEN_HI;
            S_LEN_HI: if (xfer) begin
                len_hi_d = bus.in_data;
                state_d  = S_LEN_LO;
            end
            S_LEN_LO: if (xfer) begin
                len_d   = n;
                state_d = n == '0 ? FIN : 17'(n) > 17'(MAX_WORDS) ? S_ERROR : S_DATA_HI;
            end
            S_DATA_HI: if (xfer) state_d = S_DATA_LO;
            S_DATA_LO: if (xfer) begin
                addr_d  = ADDR_W'({cnt_q, 1'b0});
                cnt_d   = cnt_q + 16'd1;
                state_d = last ? FIN : S_DATA_HI;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: if (xfer) state_d = bus.in_data == csum_q ? S_DONE : S_ERROR;
`endif
            default: state_d = S_IDLE;
        endcase
        if (restart) begin
            cnt_d  = '0;
            addr_d = '0;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d = restart ? 8'h00 : (hi_we || lo_we) ? csum_q ^ bus.in_data : csum_q;
`endif
    end
    // done waits one cycle in DONE so the final write strobe lands before the CPU is released
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            len_hi_q <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
            rdy_q    <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            hold_q   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            rdy_q    <= !(state_d inside {S_IDLE, S_DONE, S_ERROR});
            done_q   <= state_q == S_DONE && state_d == S_DONE;
            hold_q   <= !(state_q == S_DONE && state_d == S_DONE);
            err_q    <= state_d == S_ERROR;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end
    byte_pair_assembler u_asm (
        .clock   (clock),
        .reset   (reset),
        .clr_i   (restart),
        .hi_we_i (hi_we),
        .lo_we_i (lo_we),
        .data_i  (bus.in_data),
        .valid_o (bus.imem_we),
        .word_o  (bus.imem_wdata)
    );
    assign bus.in_ready  = rdy_q;
    assign bus.imem_addr = addr_q;
    assign cpu_hold_o    = hold_q;
    assign done_o        = done_q;
    assign error_o       = err_q;
    assign word_count_o  = cnt_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader; expected writes are queued as bytes are driven.
module tb_imem_loader;
    import imem_loader_pkg::*;
    logic        clock = 1'b0;
    logic        reset;
    logic        start_i;
    logic        cpu_hold_o, done_o, error_o;
    logic [15:0] word_count_o;
    int          checks = 0;
    int          errors = 0;
    int          widx = 0;
    logic        prev_we = 1'b0;
    logic [31:0] sb_q[$];
    imem_loader_if #(.ADDR_W(16)) bus ();
    imem_loader #(.MAX_WORDS(256), .ADDR_W(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .start_i      (start_i),
        .bus          (bus),
        .cpu_hold_o   (cpu_hold_o),
        .done_o       (done_o),
        .error_o      (error_o),
        .word_count_o (word_count_o)
    );
    always #5 clock = ~clock;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    always @(negedge clock) begin
        logic [31:0] e;
        if (bus.imem_we === 1'b1) begin
            chk("we_pulse", 32'(prev_we), 32'd0);
            if (sb_q.size() == 0) chk("wr_unexp", 32'd1, 32'd0);
            else begin
                e = sb_q.pop_front();
                chk("wr_addr", 32'(bus.imem_addr), 32'(e[31:16]));
                chk("wr_data", 32'(bus.imem_wdata), 32'(e[15:0]));
            end
        end
        prev_we = bus.imem_we;
    end
    task automatic pulse_start();
        start_i = 1'b1;
        @(posedge clock); #1;
        start_i = 1'b0;
        widx = 0;
    endtask
    task automatic send(input logic [7:0] b, input bit gap);
        bit rdy;
        int k;
        if (gap) begin
            bus.in_valid = 1'b0;
            @(posedge clock); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        k = 0;
        do begin
            rdy = bus.in_ready;
            @(posedge clock); #1;
            k++;
        end while (!rdy && k < 50);
        if (!rdy) chk("send_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b0;
    endtask
    task automatic wr(input logic [7:0] hi, input logic [7:0] lo, input bit gap);
        sb_q.push_back({16'(widx * 2), hi, lo});
        widx++;
        send(hi, gap);
        send(lo, gap);
    endtask
    task automatic image2(input bit gap);
        pulse_start();
        send(8'h00, gap);
        send(8'h02, gap);
        if (!gap) start_i = 1'b1;
        wr(8'h12, 8'h34, gap);
        start_i = 1'b0;
        wr(8'hAB, 8'hCD, gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h12 ^ 8'h34 ^ 8'hAB ^ 8'hCD, gap);
`else
        chk("we_lat", 32'(bus.imem_we), 32'd1);
        chk("done_early", 32'(done_o), 32'd0);
        chk("hold_early", 32'(cpu_hold_o), 32'd1);
`endif
        @(posedge clock); #1;
        chk("done", 32'(done_o), 32'd1);
        chk("hold_rel", 32'(cpu_hold_o), 32'd0);
        chk("wc2", 32'(word_count_o), 32'd2);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        reset = 1'b1;
        start_i = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_we", 32'(bus.imem_we), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_err", 32'(error_o), 32'd0);
        chk("rst_hold", 32'(cpu_hold_o), 32'd1);
        chk("rst_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_wdata", 32'(bus.imem_wdata), 32'd0);
        chk("rst_wc", 32'(word_count_o), 32'd0);
        image2(1'b0);
        image2(1'b1);
        // oversize header: 257 words
        pulse_start();
        chk("restart_hold", 32'(cpu_hold_o), 32'd1);
        send(8'h01, 1'b0);
        send(8'h01, 1'b0);
        chk("big_err", 32'(error_o), 32'd1);
        chk("big_ready", 32'(bus.in_ready), 32'd0);
        repeat (3) @(posedge clock); #1;
        chk("big_hold", 32'(cpu_hold_o), 32'd1);
        chk("big_done", 32'(done_o), 32'd0);
        chk("big_wc", 32'(word_count_o), 32'd0);
        pulse_start();
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(8'h00, 1'b0);
`endif
        @(posedge clock); #1;
        chk("zero_done", 32'(done_o), 32'd1);
        chk("zero_err", 32'(error_o), 32'd0);
        chk("zero_hold", 32'(cpu_hold_o), 32'd0);
        // reset mid-load after one word of three
        pulse_start();
        send(8'h00, 1'b0);
        send(8'h03, 1'b0);
        wr(8'h11, 8'h22, 1'b0);
        chk("mid_wc", 32'(word_count_o), 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("mid_ready", 32'(bus.in_ready), 32'd0);
        chk("mid_we", 32'(bus.imem_we), 32'd0);
        chk("mid_hold", 32'(cpu_hold_o), 32'd1);
        chk("mid_done", 32'(done_o), 32'd0);
        chk("mid_addr", 32'(bus.imem_addr), 32'd0);
        chk("mid_wdata", 32'(bus.imem_wdata), 32'd0);
        chk("mid_wc0", 32'(word_count_o), 32'd0);
        @(posedge clock); #1;
        chk("mid_idle", 32'(bus.in_ready), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse_start();
        send(8'h00, 1'b0);
        send(8'h01, 1'b0);
        wr(8'h12, 8'h34, 1'b0);
        send(8'h26, 1'b0);
        @(posedge clock); #1;
        chk("cs_ok_done", 32'(done_o), 32'd1);
        chk("cs_ok_err", 32'(error_o), 32'd0);
        pulse_start();
        send(8'h00, 1'b0);
        send(8'h01, 1'b0);
        wr(8'h12, 8'h34, 1'b0);
        send(8'h27, 1'b0);
        chk("cs_bad_err", 32'(error_o), 32'd1);
        @(posedge clock); #1;
        chk("cs_bad_done", 32'(done_o), 32'd0);
        chk("cs_bad_hold", 32'(cpu_hold_o), 32'd1);
        chk("cs_bad_wc", 32'(word_count_o), 32'd1);
`endif
        repeat (2) @(posedge clock); #1;
        chk("sb_final", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
